// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: shared memory port, redirect request and decode handshake.
// master = fetch side, slave = memory/decode/redirect side.
interface fetch_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);

  logic              m_gnt;
  logic              m_rd;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_q;

  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;

  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_pc;

  modport master (
    input  m_gnt, m_q, redir_valid, redir_pc, ir_ready,
    output m_rd, m_addr, ir_valid, ir_data, ir_pc
  );

  modport slave (
    output m_gnt, m_q, redir_valid, redir_pc, ir_ready,
    input  m_rd, m_addr, ir_valid, ir_data, ir_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, credit-limited reads, DEPTH-entry queue, zero-bubble redirect.
// Optional macro FETCH_BYPASS_EN: a response arriving into an empty queue goes straight to ir_*.
module fetch_unit #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clock,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] tag_pc;
  logic              inflight;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc   [DEPTH];

  logic              queue_empty;
  logic              has_credit;
  logic              issue;
  logic              resp;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] next_addr;
  logic [CNT_W:0]    credit_used;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_pc;

  always_comb begin
    queue_empty = (count == '0);
    credit_used = {1'b0, count} + (CNT_W+1)'(inflight);
    has_credit  = (credit_used < (CNT_W+1)'(DEPTH));
    next_addr   = bus.redir_valid ? bus.redir_pc : fetch_pc;
    // Gating with reset keeps m_rd low while reset is held, without waiting for an edge.
    issue       = reset & bus.m_gnt & (bus.redir_valid | has_credit);
    // A response landing in a redirect cycle belongs to the old path and is dropped.
    resp        = inflight & ~bus.redir_valid;
    pop         = ~queue_empty & bus.ir_ready & ~bus.redir_valid;
`ifdef FETCH_BYPASS_EN
    out_valid   = ~queue_empty | resp;
    out_data    = queue_empty ? bus.m_q : q_data[rd_ptr];
    out_pc      = queue_empty ? tag_pc  : q_pc[rd_ptr];
    push        = resp & ~(queue_empty & bus.ir_ready);
`else
    out_valid   = ~queue_empty;
    out_data    = q_data[rd_ptr];
    out_pc      = q_pc[rd_ptr];
    push        = resp;
`endif
  end

  assign bus.m_rd     = issue;
  assign bus.m_addr   = next_addr;
  assign bus.ir_valid = out_valid;
  assign bus.ir_data  = out_data;
  assign bus.ir_pc    = out_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int unsigned i = 0; i < unsigned'(DEPTH); i++) begin
        q_data[PTR_W'(i)] <= '0;
        q_pc[PTR_W'(i)]   <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_pc   <= next_addr;
        fetch_pc <= next_addr + ADDR_W'(1);
      end else if (bus.redir_valid) begin
        fetch_pc <= bus.redir_pc;
      end

      if (push) begin
        q_data[wr_ptr] <= bus.m_q;
        q_pc[wr_ptr]   <= tag_pc;
      end

      if (bus.redir_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule
